axi_chan_slice: RTL and testbench

AXI_CHAN_SLICE -- requirements
Module: axi_chan_slice

---
 rtl/axi_chan_slice_pkg.sv | 15 +
 rtl/axi_chan_slice_if.sv | 14 +
 rtl/axi_chan_slice_stage.sv | 74 +++++++
 rtl/axi_chan_slice.sv | 33 +++
 tb/tb_axi_chan_slice.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/axi_chan_slice_pkg.sv
// axi_chan_slice_pkg: shared AXI widths and register-slice mode encodings.
package axi_chan_slice_pkg;
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 128;
  localparam int AXI_ID_W   = 4;
  localparam int AXI_USER_W = 1;
  typedef enum logic [1:0] {
    SLICE_BYPASS = 2'd0,
    SLICE_FWD    = 2'd1,
    SLICE_FULL   = 2'd2
  } slice_mode_e;
  function automatic logic [1:0] slice_mode_of(input logic [63:0] vec, input int ch);
    return vec[2*ch +: 2];
  endfunction
endpackage

// File: rtl/axi_chan_slice_if.sv
// axi_chan_slice_if: bundled per-channel valid/ready/payload for the slice.
interface axi_chan_slice_if #(
  parameter int NUM_CH = 5,
  parameter int DW = 128
);
  logic [NUM_CH-1:0] s_valid;
  logic [NUM_CH-1:0] s_ready;
  logic [NUM_CH*DW-1:0] s_data;
  logic [NUM_CH-1:0] m_valid;
  logic [NUM_CH-1:0] m_ready;
  logic [NUM_CH*DW-1:0] m_data;
  modport slave (input s_valid, s_data, m_ready, output s_ready, m_valid, m_data);
  modport master (output s_valid, s_data, m_ready, input s_ready, m_valid, m_data);
endinterface

// File: rtl/axi_chan_slice_stage.sv
// axi_slice_stage: one valid/ready channel as bypass wire, forward register or 2-entry skid buffer.
module axi_slice_stage
  import axi_chan_slice_pkg::*;
#(
  parameter int DW = 128,
  parameter logic [1:0] MODE = SLICE_FULL
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          empty_next
);
  if (MODE == SLICE_BYPASS) begin : g_bypass
    logic unused_clk;
    assign unused_clk = clk ^ rst_n;
    assign m_valid = s_valid;
    assign m_data = s_data;
    assign s_ready = m_ready;
    assign empty_next = 1'b1;
  end else if (MODE == SLICE_FWD) begin : g_fwd
    // live holds s_ready low through reset and rises on the first edge after release
    logic live, full, push;
    logic [DW-1:0] data;
    assign s_ready = live & (!full | m_ready);
    assign push = s_valid & s_ready;
    assign m_valid = full;
    assign m_data = data;
    assign empty_next = !push & !(full & !m_ready);
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        live <= 1'b0;
        full <= 1'b0;
        data <= '0;
      end else begin
        live <= 1'b1;
        full <= push | (full & !m_ready);
        if (push) data <= s_data;
      end
    end
  end else if (MODE == SLICE_FULL) begin : g_full
    // head is always the oldest beat; tail only fills when a second beat arrives without a pop
    logic [1:0] count, count_n;
    logic rdy, push, pop;
    logic [DW-1:0] head, tail;
    assign push = s_valid & rdy;
    assign pop = (count != 2'd0) & m_ready;
    assign count_n = count + {1'b0, push} - {1'b0, pop};
    assign s_ready = rdy;
    assign m_valid = count != 2'd0;
    assign m_data = head;
    assign empty_next = count_n == 2'd0;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        count <= 2'd0;
        rdy <= 1'b0;
        head <= '0;
        tail <= '0;
      end else begin
        count <= count_n;
        rdy <= count_n != 2'd2;
        if (pop && count == 2'd2) head <= tail;
        else if (push && (count == 2'd0 || pop)) head <= s_data;
        if (push && count == 2'd1 && !pop) tail <= s_data;
      end
    end
  end else begin : g_illegal
    $error("axi_slice_stage: MODE=3 is not a legal slice mode");
  end
endmodule

// File: rtl/axi_chan_slice.sv
// axi_chan_slice: NUM_CH independent valid/ready register slices with a registered idle flag.
module axi_chan_slice
  import axi_chan_slice_pkg::*;
#(
  parameter int NUM_CH = 5,
  parameter int DW = 128,
  parameter logic [2*NUM_CH-1:0] MODE_VEC = {NUM_CH{2'd2}}
) (
  input  logic aclk,
  input  logic areset_n,
  axi_chan_slice_if.slave bus,
  output logic idle
);
  logic [NUM_CH-1:0] empty_next;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    axi_slice_stage #(.DW(DW), .MODE(MODE_VEC[2*i +: 2])) u_stage (
      .clk        (aclk),
      .rst_n      (areset_n),
      .s_valid    (bus.s_valid[i]),
      .s_ready    (bus.s_ready[i]),
      .s_data     (bus.s_data[i*DW +: DW]),
      .m_valid    (bus.m_valid[i]),
      .m_ready    (bus.m_ready[i]),
      .m_data     (bus.m_data[i*DW +: DW]),
      .empty_next (empty_next[i])
    );
  end
  // registering next-cycle emptiness makes idle match the current occupancy exactly
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) idle <= 1'b1;
    else idle <= &empty_next;
  end
endmodule

// File: tb/tb_axi_chan_slice.sv
// tb_axi_chan_slice: randomized and directed stimulus against a per-channel FIFO reference model.
module tb_axi_chan_slice;
  localparam int N = 5;
  localparam int W = 16;
  localparam logic [2*N-1:0] MV = {2'd2, 2'd2, 2'd0, 2'd1, 2'd2};
  logic aclk = 1'b0;
  logic areset_n = 1'b0;
  logic idle;
  axi_chan_slice_if #(.NUM_CH(N), .DW(W)) bus ();
  axi_chan_slice #(.NUM_CH(N), .DW(W), .MODE_VEC(MV)) dut (
    .aclk(aclk), .areset_n(areset_n), .bus(bus), .idle(idle)
  );
  always #5 aclk = ~aclk;
  int errs = 0, checks = 0;
  int mode[N] = '{2, 1, 0, 2, 2};
  int pv[N], pr[N], pops[N];
  logic [W-1:0] q[N][$];
  logic [W-1:0] dq[N][$];
  bit held[N], from_dq[N];
  bit live = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic sample();
    bit all_empty = 1;
    for (int c = 0; c < N; c++) if (mode[c] != 0 && q[c].size() != 0) all_empty = 0;
    check("idle", idle, all_empty);
    for (int c = 0; c < N; c++) begin
      logic sv, sr, mvl, mr, er;
      logic [W-1:0] sd, md;
      sv = bus.s_valid[c]; sr = bus.s_ready[c]; sd = bus.s_data[c*W +: W];
      mvl = bus.m_valid[c]; mr = bus.m_ready[c]; md = bus.m_data[c*W +: W];
      if (mode[c] == 0) begin
        check($sformatf("ch%0d_byp_mvalid", c), mvl, sv);
        check($sformatf("ch%0d_byp_sready", c), sr, mr);
        if (sv) check($sformatf("ch%0d_byp_mdata", c), md, sd);
      end else begin
        check($sformatf("ch%0d_mvalid", c), mvl, q[c].size() > 0);
        if (q[c].size() > 0) check($sformatf("ch%0d_mdata", c), md, q[c][0]);
        er = !live ? 1'b0 : mode[c] == 2 ? (q[c].size() < 2) : (q[c].size() == 0 || mr);
        check($sformatf("ch%0d_sready", c), sr, er);
        if (mvl && mr && q[c].size() > 0) void'(q[c].pop_front());
        if (sv && sr) q[c].push_back(sd);
      end
      if (mvl && mr) pops[c]++;
      if (sv && sr && from_dq[c] && dq[c].size() > 0) void'(dq[c].pop_front());
      held[c] = sv && !sr;
    end
    if (areset_n) live = 1;
  endtask
  task automatic drive();
    for (int c = 0; c < N; c++) begin
      if (!held[c]) begin
        from_dq[c] = dq[c].size() > 0;
        bus.s_valid[c] = from_dq[c] ? 1'b1 : ($urandom_range(99) < pv[c]);
        bus.s_data[c*W +: W] = from_dq[c] ? dq[c][0] : W'($urandom);
      end
      bus.m_ready[c] = pr[c] > 100 ? ~bus.m_ready[c] : ($urandom_range(99) < pr[c]);
    end
  endtask
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge aclk);
      sample();
      @(posedge aclk);
      #1;
      drive();
    end
  endtask
  task automatic set_all(input int v, input int r);
    for (int c = 0; c < N; c++) begin
      pv[c] = v;
      pr[c] = r;
    end
  endtask
  initial begin
    bus.s_valid = '0;
    bus.s_data = '0;
    bus.m_ready = '0;
    set_all(0, 100);
    step(3);
    areset_n = 1'b1;
    step(2);
    set_all(60, 60);
    step(200);
    set_all(0, 100);
    step(5);
    dq[0] = '{16'h11, 16'h22, 16'h33};
    step(6);
    pr[4] = 0;
    dq[4] = '{16'hA, 16'hB};
    step(4);
    pr[4] = 100;
    step(4);
    pv[1] = 100;
    pr[1] = 101;
    step(30);
    set_all(100, 100);
    pr[1] = 0;
    step(2);
    for (int c = 0; c < N; c++) pops[c] = 0;
    step(20);
    for (int c = 0; c < N; c++) if (c != 1) check($sformatf("ch%0d_tput", c), pops[c] >= 19, 1'b1);
    set_all(0, 100);
    step(4);
    for (int c = 0; c < N; c++) begin
      pv[c] = $urandom_range(20, 95);
      pr[c] = $urandom_range(20, 95);
    end
    step(300);
    set_all(0, 100);
    step(4);
    pr[4] = 0;
    dq[4] = '{16'hBEEF, 16'hCAFE};
    step(4);
    check("ch4_full_sready", bus.s_ready[4], 1'b0);
    #2 areset_n = 1'b0;
    #1;
    check("rst_ch4_mvalid", bus.m_valid[4], 1'b0);
    check("rst_ch4_sready", bus.s_ready[4], 1'b0);
    check("rst_ch1_mvalid", bus.m_valid[1], 1'b0);
    check("rst_idle", idle, 1'b1);
    for (int c = 0; c < N; c++) begin
      q[c].delete();
      dq[c].delete();
      held[c] = 0;
      from_dq[c] = 0;
    end
    live = 0;
    step(2);
    areset_n = 1'b1;
    set_all(60, 100);
    step(50);
    set_all(0, 100);
    step(4);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
